// File: rtl/idex_hazard_reg.sv
// ID/EX pipeline register with load-use stall detection and one-stage-early
// forwarding select computation for the EX operand mux.
module idex_hazard_reg #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              id_valid,
    input  logic [6:0]        id_op,
    input  logic [REG_W-1:0]  id_rd,
    input  logic [REG_W-1:0]  id_rs1,
    input  logic [REG_W-1:0]  id_rs2,
    input  logic              id_regwrite,
    input  logic [DATA_W-1:0] id_data1,
    input  logic [DATA_W-1:0] id_data2,
    input  logic [DATA_W-1:0] id_s_data,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_W-1:0]  exmem_rd,
    input  logic              exmem_regwrite,
    output logic              stall,
    output logic              ex_valid,
    output logic [6:0]        ex_op,
    output logic [REG_W-1:0]  ex_rd,
    output logic [REG_W-1:0]  ex_rs1,
    output logic [REG_W-1:0]  ex_rs2,
    output logic              ex_regwrite,
    output logic [DATA_W-1:0] ex_data1,
    output logic [DATA_W-1:0] ex_data2,
    output logic [DATA_W-1:0] ex_s_data,
    output logic [DATA_W-1:0] ex_imm,
    output logic [1:0]        forwA,
    output logic [1:0]        forwB
);

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;

    localparam logic [1:0] FW_RF    = 2'b00;
    localparam logic [1:0] FW_EXMEM = 2'b01;
    localparam logic [1:0] FW_MEMWB = 2'b10;

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_R || op == OP_S || op == OP_B);
    endfunction

    logic              r_ex_valid;
    logic [6:0]        r_ex_op;
    logic [REG_W-1:0]  r_ex_rd;
    logic [REG_W-1:0]  r_ex_rs1;
    logic [REG_W-1:0]  r_ex_rs2;
    logic              r_ex_regwrite;
    logic [DATA_W-1:0] r_ex_data1;
    logic [DATA_W-1:0] r_ex_data2;
    logic [DATA_W-1:0] r_ex_s_data;
    logic [DATA_W-1:0] r_ex_imm;
    logic [1:0]        r_forwA;
    logic [1:0]        r_forwB;

    logic w_src1_live, w_src2_live;
    logic w_ex_hit1, w_ex_hit2, w_mem_hit1, w_mem_hit2;
    logic w_stall;

    // A source only counts as a hazard if it is a real, non-x0 read.
    assign w_src1_live = id_valid && uses_rs1(id_op) && (id_rs1 != '0);
    assign w_src2_live = id_valid && uses_rs2(id_op) && (id_rs2 != '0);

    assign w_ex_hit1  = w_src1_live && r_ex_valid && r_ex_regwrite && (r_ex_rd == id_rs1);
    assign w_ex_hit2  = w_src2_live && r_ex_valid && r_ex_regwrite && (r_ex_rd == id_rs2);
    assign w_mem_hit1 = w_src1_live && exmem_regwrite && (exmem_rd == id_rs1);
    assign w_mem_hit2 = w_src2_live && exmem_regwrite && (exmem_rd == id_rs2);

    // Load data is not ready for an EX-stage forward, so a load match stalls instead.
    assign w_stall = !flush && (r_ex_op == OP_LOAD) && (w_ex_hit1 || w_ex_hit2);
    assign stall   = w_stall;

    always_ff @(posedge clk or posedge reset) begin
        if (reset || flush || w_stall) begin
            if (reset || flush || w_stall) begin
                r_ex_valid    <= 1'b0;
                r_ex_op       <= '0;
                r_ex_rd       <= '0;
                r_ex_rs1      <= '0;
                r_ex_rs2      <= '0;
                r_ex_regwrite <= 1'b0;
                r_ex_data1    <= '0;
                r_ex_data2    <= '0;
                r_ex_s_data   <= '0;
                r_ex_imm      <= '0;
                r_forwA       <= FW_RF;
                r_forwB       <= FW_RF;
            end
        end else begin
            r_ex_valid    <= id_valid;
            r_ex_op       <= id_op;
            r_ex_rd       <= id_rd;
            r_ex_rs1      <= id_rs1;
            r_ex_rs2      <= id_rs2;
            r_ex_regwrite <= id_regwrite;
            r_ex_data1    <= id_data1;
            r_ex_data2    <= id_data2;
            r_ex_s_data   <= id_s_data;
            r_ex_imm      <= id_imm;
            r_forwA       <= w_ex_hit1 ? FW_EXMEM : (w_mem_hit1 ? FW_MEMWB : FW_RF);
            r_forwB       <= w_ex_hit2 ? FW_EXMEM : (w_mem_hit2 ? FW_MEMWB : FW_RF);
        end
    end

    assign ex_valid    = r_ex_valid;
    assign ex_op       = r_ex_op;
    assign ex_rd       = r_ex_rd;
    assign ex_rs1      = r_ex_rs1;
    assign ex_rs2      = r_ex_rs2;
    assign ex_regwrite = r_ex_regwrite;
    assign ex_data1    = r_ex_data1;
    assign ex_data2    = r_ex_data2;
    assign ex_s_data   = r_ex_s_data;
    assign ex_imm      = r_ex_imm;
    assign forwA       = r_forwA;
    assign forwB       = r_forwB;

endmodule

// File: tb/tb_idex_hazard_reg.sv
// Directed bench for idex_hazard_reg: reset, forwarding priority, load-use stall, flush.
module tb_idex_hazard_reg;

    logic        clk = 1'b0;
    logic        reset, flush, id_valid, id_regwrite, exmem_regwrite;
    logic [6:0]  id_op;
    logic [4:0]  id_rd, id_rs1, id_rs2, exmem_rd;
    logic [31:0] id_data1, id_data2, id_s_data, id_imm;
    logic        stall, ex_valid, ex_regwrite;
    logic [6:0]  ex_op;
    logic [4:0]  ex_rd, ex_rs1, ex_rs2;
    logic [31:0] ex_data1, ex_data2, ex_s_data, ex_imm;
    logic [1:0]  forwA, forwB;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [6:0] R   = 7'b0110011;
    localparam logic [6:0] I   = 7'b0010011;
    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ST  = 7'b0100011;

    idex_hazard_reg #(.DATA_W(32), .REG_W(5)) dut (
        .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid), .id_op(id_op),
        .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_regwrite(id_regwrite),
        .id_data1(id_data1), .id_data2(id_data2), .id_s_data(id_s_data), .id_imm(id_imm),
        .exmem_rd(exmem_rd), .exmem_regwrite(exmem_regwrite), .stall(stall),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_rd(ex_rd), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_regwrite(ex_regwrite), .ex_data1(ex_data1), .ex_data2(ex_data2),
        .ex_s_data(ex_s_data), .ex_imm(ex_imm), .forwA(forwA), .forwB(forwB)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic id_set(input logic v, input logic [6:0] op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic rw,
                          input logic [31:0] d1, input logic [31:0] d2);
        id_valid = v; id_op = op; id_rd = rd; id_rs1 = rs1; id_rs2 = rs2;
        id_regwrite = rw; id_data1 = d1; id_data2 = d2;
        id_s_data = d2 ^ 32'h00FF_0000; id_imm = d1 + 32'h100;
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; exmem_rd = '0; exmem_regwrite = 1'b0;
        id_set(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0);
        step;
        chk("rst_valid", {31'd0, ex_valid}, 32'd0);
        chk("rst_forw", {28'd0, forwA, forwB}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        reset = 1'b0;

        // Back-to-back ALU: add x5,x1,x2 then add x6,x5,x5
        id_set(1'b1, R, 5'd5, 5'd1, 5'd2, 1'b1, 32'h11, 32'h22);
        step;
        chk("alu1_valid", {31'd0, ex_valid}, 32'd1);
        chk("alu1_rd", {27'd0, ex_rd}, 32'd5);
        chk("alu1_data1", ex_data1, 32'h11);
        chk("alu1_imm", ex_imm, 32'h111);
        id_set(1'b1, R, 5'd6, 5'd5, 5'd5, 1'b1, 32'h33, 32'h44);
        #1 chk("alu2_stall", {31'd0, stall}, 32'd0);
        step;
        chk("alu2_forwA", {30'd0, forwA}, 32'd1);
        chk("alu2_forwB", {30'd0, forwB}, 32'd1);
        chk("alu2_sdata", ex_s_data, 32'h00FF_0044);

        // Asynchronous reset while EX holds a valid instruction
        #2 reset = 1'b1;
        #1;
        chk("mrst_valid", {31'd0, ex_valid}, 32'd0);
        chk("mrst_rd", {27'd0, ex_rd}, 32'd0);
        chk("mrst_data1", ex_data1, 32'd0);
        chk("mrst_forw", {28'd0, forwA, forwB}, 32'd0);
        chk("mrst_stall", {31'd0, stall}, 32'd0);
        #1 reset = 1'b0;
        @(negedge clk);

        // Priority: EX rd=x5 and EX/MEM rd=x5 both match rs1=x5
        id_set(1'b1, I, 5'd5, 5'd1, 5'd0, 1'b1, 32'h1, 32'h0);
        step;
        id_set(1'b1, I, 5'd8, 5'd5, 5'd5, 1'b1, 32'h2, 32'h0);
        exmem_rd = 5'd5; exmem_regwrite = 1'b1;
        step;
        chk("prio_forwA", {30'd0, forwA}, 32'd1);
        chk("prio_forwB_unused", {30'd0, forwB}, 32'd0);
        // Invalid slot carrying rd=x5: captured as a bubble with forw=00
        id_set(1'b0, I, 5'd5, 5'd5, 5'd0, 1'b1, 32'h3, 32'h0);
        step;
        chk("inv_valid", {31'd0, ex_valid}, 32'd0);
        chk("inv_forwA", {30'd0, forwA}, 32'd0);
        id_set(1'b1, I, 5'd8, 5'd5, 5'd0, 1'b1, 32'h4, 32'h0);
        step;
        chk("prio_memwb", {30'd0, forwA}, 32'd2);
        exmem_regwrite = 1'b0;

        // x0 never forwards; addi does not read its rs2 field
        id_set(1'b1, R, 5'd0, 5'd1, 5'd2, 1'b1, 32'h5, 32'h6);
        step;
        id_set(1'b1, R, 5'd10, 5'd0, 5'd0, 1'b1, 32'h7, 32'h8);
        step;
        chk("x0_forw", {28'd0, forwA, forwB}, 32'd0);
        id_set(1'b1, I, 5'd9, 5'd1, 5'd0, 1'b1, 32'h9, 32'h0);
        step;
        id_set(1'b1, I, 5'd11, 5'd1, 5'd9, 1'b1, 32'hA, 32'h0);
        #1 chk("unused_stall", {31'd0, stall}, 32'd0);
        step;
        chk("unused_forw", {28'd0, forwA, forwB}, 32'd0);

        // Load-use: lw x7 then sw x7,0(x7)
        id_set(1'b1, LD, 5'd7, 5'd1, 5'd0, 1'b1, 32'hB, 32'h0);
        step;
        id_set(1'b1, ST, 5'd0, 5'd7, 5'd7, 1'b0, 32'h70, 32'h77);
        #1 chk("lu_stall", {31'd0, stall}, 32'd1);
        step;
        chk("lu_bubble_valid", {31'd0, ex_valid}, 32'd0);
        chk("lu_bubble_op", {25'd0, ex_op}, 32'd0);
        chk("lu_bubble_forw", {28'd0, forwA, forwB}, 32'd0);
        chk("lu_no_restall", {31'd0, stall}, 32'd0);
        exmem_rd = 5'd7; exmem_regwrite = 1'b1;
        step;
        chk("lu_valid", {31'd0, ex_valid}, 32'd1);
        chk("lu_op", {25'd0, ex_op}, 32'h23);
        chk("lu_forw", {28'd0, forwA, forwB}, 32'hA);
        chk("lu_data2", ex_data2, 32'h77);
        exmem_regwrite = 1'b0;

        // Flush overrides a load-use condition
        id_set(1'b1, LD, 5'd7, 5'd1, 5'd0, 1'b1, 32'hC, 32'h0);
        step;
        id_set(1'b1, R, 5'd3, 5'd1, 5'd7, 1'b1, 32'hD, 32'hE);
        #1 chk("lu_rs2_stall", {31'd0, stall}, 32'd1);
        id_set(1'b1, ST, 5'd0, 5'd7, 5'd7, 1'b0, 32'h70, 32'h77);
        flush = 1'b1;
        #1 chk("fl_stall", {31'd0, stall}, 32'd0);
        step;
        chk("fl_valid", {31'd0, ex_valid}, 32'd0);
        chk("fl_op", {25'd0, ex_op}, 32'd0);
        flush = 1'b0;
        id_set(1'b1, R, 5'd12, 5'd1, 5'd2, 1'b1, 32'hF, 32'h10);
        #1 chk("fl_after_stall", {31'd0, stall}, 32'd0);
        step;
        chk("fl_after_valid", {31'd0, ex_valid}, 32'd1);
        chk("fl_after_rd", {27'd0, ex_rd}, 32'd12);
        chk("fl_after_forw", {28'd0, forwA, forwB}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
